// File: rtl/miriscv_dmem.sv
// Data-side memory slave: word RAM with byte-lane writes plus a small MMIO block
// (GPIO, free-running cycle counter, sticky bus-error status). Read data is registered.
module miriscv_dmem #(
  parameter int unsigned RAM_WORDS      = 1024,
  parameter logic [31:0] RDATA_UNMAPPED = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic [31:0] gpio_o,
  output logic        err_o
);

  // Handshake: a request is accepted whenever data_req_i is high at a rising edge;
  // there is no ready/wait, and read data appears on data_rdata_o after that edge.

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [28:0] RAM_LIMIT = 29'(RAM_WORDS);

  logic [31:0] mem [RAM_WORDS];

  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic          ram_sel, mmio_ok, gpio_sel, cnt_sel, st_sel, mapped;
  logic          rd_en, wr_en;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rd_val;
  logic          unused_addr;

  assign unused_addr = ^data_addr_i[1:0];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Word index is addr[31:2]; with addr[31] clear it is addr[30:2].
  assign ram_idx  = data_addr_i[AW+1:2];
  assign ram_sel  = !data_addr_i[31] && (data_addr_i[30:2] < RAM_LIMIT);
  assign mmio_ok  = data_addr_i[31] && (data_addr_i[30:4] == 27'd0);
  assign gpio_sel = mmio_ok && (data_addr_i[3:2] == 2'd0);
  assign cnt_sel  = mmio_ok && (data_addr_i[3:2] == 2'd1);
  assign st_sel   = mmio_ok && (data_addr_i[3:2] == 2'd2);
  assign mapped   = ram_sel || gpio_sel || cnt_sel || st_sel;
  assign rd_en    = data_req_i && !data_we_i;
  assign wr_en    = data_req_i && data_we_i;

  always_comb begin
    rd_val = RDATA_UNMAPPED;
    if (ram_sel)       rd_val = mem[ram_idx];
    else if (gpio_sel) rd_val = gpio_q;
    else if (cnt_sel)  rd_val = cnt_q;
    else if (st_sel)   rd_val = {31'd0, err_q};
  end

  always_comb begin
    rdata_d = rdata_q;
    gpio_d  = gpio_q;
    cnt_d   = cnt_q + 32'd1;
    err_d   = err_q;
    if (rd_en) rdata_d = rd_val;
    if (wr_en && gpio_sel) gpio_d = merge_lanes(gpio_q, data_wdata_i, data_be_i);
    // A counter write suppresses this cycle's increment on every lane.
    if (wr_en && cnt_sel)  cnt_d  = merge_lanes(cnt_q, data_wdata_i, data_be_i);
    if (wr_en && st_sel && data_be_i[0] && data_wdata_i[0]) err_d = 1'b0;
    if (data_req_i && !mapped) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q <= 32'd0;
      gpio_q  <= 32'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) mem[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  assign data_rdata_o = rdata_q;
  assign gpio_o       = gpio_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_miriscv_dmem.sv
// Directed bench for miriscv_dmem: vector table for single-cycle accesses plus
// hand-written counter and reset sequences.
module tb_miriscv_dmem;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic [31:0] data_rdata_o;
  logic [31:0] gpio_o;
  logic        err_o;

  int n_pass = 0;
  int n_total = 0;

  miriscv_dmem #(.RAM_WORDS(1024), .RDATA_UNMAPPED(32'h0000_0000)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .gpio_o       (gpio_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_gpio;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one request, let the next rising edge sample it, return #1 after that edge.
  task automatic acc(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"ram_wr_full",   1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[1]  = '{"ram_wr_be0101", 1, 4'h5, 32'h0000_0010, 32'hAABB_CCDD, 32'h0000_0000, 32'h0000_0000, 0};
    vecs[2]  = '{"ram_rd_merge",  0, 4'hF, 32'h0000_0010, 32'h0,         32'h11BB_33DD, 32'h0000_0000, 0};
    vecs[3]  = '{"gpio_wr_lo",    1, 4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h11BB_33DD, 32'h0000_FFFF, 0};
    vecs[4]  = '{"gpio_rd_be0",   0, 4'h0, 32'h8000_0000, 32'h0,         32'h0000_FFFF, 32'h0000_FFFF, 0};
    vecs[5]  = '{"ram_wr_be0",    1, 4'h0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_FFFF, 0};
    vecs[6]  = '{"ram_rd_nochg",  0, 4'hF, 32'h0000_0010, 32'h0,         32'h11BB_33DD, 32'h0000_FFFF, 0};
    vecs[7]  = '{"ram_wr_last",   1, 4'hF, 32'h0000_0FFC, 32'h600D_F00D, 32'h11BB_33DD, 32'h0000_FFFF, 0};
    vecs[8]  = '{"ram_rd_last",   0, 4'h0, 32'h0000_0FFC, 32'h0,         32'h600D_F00D, 32'h0000_FFFF, 0};
    vecs[9]  = '{"rd_past_ram",   0, 4'hF, 32'h0000_1000, 32'h0,         32'h0000_0000, 32'h0000_FFFF, 1};
    vecs[10] = '{"rd_mmio_0xC",   0, 4'hF, 32'h8000_000C, 32'h0,         32'h0000_0000, 32'h0000_FFFF, 1};
    vecs[11] = '{"rd_status_1",   0, 4'hF, 32'h8000_0008, 32'h0,         32'h0000_0001, 32'h0000_FFFF, 1};
    vecs[12] = '{"st_wr_data0",   1, 4'h1, 32'h8000_0008, 32'h0000_0000, 32'h0000_0001, 32'h0000_FFFF, 1};
    vecs[13] = '{"st_wr_nobe0",   1, 4'h2, 32'h8000_0008, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF, 1};
    vecs[14] = '{"st_clear",      1, 4'h1, 32'h8000_0008, 32'h0000_0001, 32'h0000_0001, 32'h0000_FFFF, 0};
    vecs[15] = '{"rd_status_0",   0, 4'hF, 32'h8000_0008, 32'h0,         32'h0000_0000, 32'h0000_FFFF, 0};
    vecs[16] = '{"wr_mmio_hi",    1, 4'hF, 32'h8000_1000, 32'h1234_5678, 32'h0000_0000, 32'h0000_FFFF, 1};
    vecs[17] = '{"st_clear2",     1, 4'hF, 32'h8000_0008, 32'h0000_0001, 32'h0000_0000, 32'h0000_FFFF, 0};
    vecs[18] = '{"gpio_wr_hi",    1, 4'hC, 32'h8000_0000, 32'hA5A5_0000, 32'h0000_0000, 32'hA5A5_FFFF, 0};
    vecs[19] = '{"rd_mmio_0x10",  0, 4'hF, 32'h8000_0010, 32'h0,         32'h0000_0000, 32'hA5A5_FFFF, 1};
    vecs[20] = '{"st_clear3",     1, 4'h1, 32'h8000_0008, 32'h0000_0001, 32'h0000_0000, 32'hA5A5_FFFF, 0};
    vecs[21] = '{"wr_alias",      1, 4'hF, 32'h0000_1010, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_FFFF, 1};
    vecs[22] = '{"rd_no_alias",   0, 4'hF, 32'h0000_0010, 32'h0,         32'h11BB_33DD, 32'hA5A5_FFFF, 1};
    vecs[23] = '{"st_clear4",     1, 4'h1, 32'h8000_0008, 32'h0000_0001, 32'h11BB_33DD, 32'hA5A5_FFFF, 0};

    // Reset and idle-state checks
    repeat (2) @(posedge clk_i);
    #3;
    arst_i = 1'b0;
    check("rst_rdata", data_rdata_o, 32'h0);
    check("rst_gpio", gpio_o, 32'h0);
    check("rst_err", {31'd0, err_o}, 32'h0);
    acc(0, 4'hF, 32'h8000_0004, 32'h0);
    check("cnt_first", data_rdata_o, 32'h0);
    acc(0, 4'hF, 32'h8000_0004, 32'h0);
    check("cnt_second", data_rdata_o, 32'h1);
    acc(0, 4'hF, 32'h8000_0000, 32'h0);
    check("rst_rd_gpio", data_rdata_o, 32'h0);
    acc(0, 4'hF, 32'h8000_0008, 32'h0);
    check("rst_rd_status", data_rdata_o, 32'h0);

    for (int i = 0; i < 24; i++) begin
      acc(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_rdata"}, data_rdata_o, vecs[i].exp_rdata);
      check({vecs[i].name, "_gpio"}, gpio_o, vecs[i].exp_gpio);
      check({vecs[i].name, "_err"}, {31'd0, err_o}, {31'd0, vecs[i].exp_err});
    end

    // Counter wrap and partial-lane write
    acc(1, 4'hF, 32'h8000_0004, 32'hFFFF_FFFE);
    idle();
    idle();
    acc(0, 4'hF, 32'h8000_0004, 32'h0);
    check("cnt_wrap", data_rdata_o, 32'h0);
    acc(1, 4'hF, 32'h8000_0004, 32'h0000_1233);
    acc(1, 4'h1, 32'h8000_0004, 32'h0000_0005);
    acc(0, 4'hF, 32'h8000_0004, 32'h0);
    check("cnt_lane_wr", data_rdata_o, 32'h0000_1205);
    acc(0, 4'hF, 32'h8000_0004, 32'h0);
    check("cnt_resume", data_rdata_o, 32'h0000_1206);

    // Reset in the middle of a pending read
    acc(1, 4'hF, 32'h0000_0040, 32'h1357_9BDF);
    acc(0, 4'hF, 32'h0000_0010, 32'h0);
    check("pre_rst_rdata", data_rdata_o, 32'h11BB_33DD);
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h0000_0040;
    #2;
    arst_i = 1'b1;
    #1;
    check("mid_rst_rdata", data_rdata_o, 32'h0);
    check("mid_rst_gpio", gpio_o, 32'h0);
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
    arst_i = 1'b0;
    idle();
    check("post_rst_hold", data_rdata_o, 32'h0);
    acc(0, 4'hF, 32'h0000_0040, 32'h0);
    check("post_rst_ram", data_rdata_o, 32'h1357_9BDF);
    check("post_rst_err", {31'd0, err_o}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/miriscv_dmem.md
Name: miriscv_dmem

Overview:
- Data-side memory slave directly downstream of the core's load/store unit.
- Accepts the core's single-request data bus (req/we/be/addr/wdata) and returns read data registered one cycle later, which matches the LSU's one-cycle stall.
- Contains a word-organised data RAM with byte-lane writes and a small MMIO region: GPIO output register, free-running cycle counter, and a sticky bus-error status.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words (power of two, ≥ 4).
- RDATA_UNMAPPED, 32'h0000_0000, value returned for reads of unmapped addresses.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-high.
- data_req_i  in  1  access request; sampled on rising clk_i.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; bit n covers wdata[8n+7:8n].
- data_addr_i  in  32  byte address; bits [1:0] ignored (word-aligned access).
- data_wdata_i  in  32  write data, already lane-aligned by the LSU.
- data_rdata_o  out  32  read data, registered.
- gpio_o  out  32  GPIO output register.
- err_o  out  1  sticky bus-error flag.

Behaviour:
- One clock domain. arst_i is asynchronous, active-high.
- Reset values: data_rdata_o = 0, gpio_o = 0, cycle counter = 0, err_o = 0. RAM contents are not reset; the bench must not check them before writing.
- Reset asserted mid-operation aborts any pending read; data_rdata_o stays 0 until the first read after release.
- Address decode:
  - addr[31] = 0 is RAM. Word index = addr[31:2]. Index < RAM_WORDS is mapped; index ≥ RAM_WORDS is unmapped. No aliasing.
  - addr[31] = 1 is MMIO, decoded on addr[3:0] with addr[30:4] required to be 0:
    - 0x0 GPIO (RW)
    - 0x4 CNT (RW)
    - 0x8 STATUS (RW; bit0 = err, W1C; other bits read 0)
    - any other offset is unmapped.
- Write (req = 1, we = 1):
  - Takes effect at the sampling edge; only lanes with be = 1 are updated.
  - be = 4'b0000 is a legal no-op and updates nothing.
  - data_rdata_o holds its previous value.
- Read (req = 1, we = 0):
  - data_rdata_o updates at the sampling edge with the full word, regardless of be. Data is valid in the following cycle (latency 1).
  - A read in cycle N+1 of a word written in cycle N returns the new data.
- req = 0: no state change except the counter; data_rdata_o holds.
- Counter:
  - Increments by 1 every cycle; wraps 32'hFFFF_FFFF → 0.
  - A read returns the pre-increment value present at the sampling edge.
  - A write in the same cycle wins over the increment: byte-enabled lanes load wdata, unwritten lanes keep the current value without increment, and counting resumes next cycle.
- Error flag:
  - err set at the edge of any unmapped access (read or write).
  - An unmapped read returns RDATA_UNMAPPED; an unmapped write changes no state.
  - Writing STATUS with be[0] = 1 and wdata[0] = 1 clears err.
  - A new error in the same cycle as the clear leaves err = 1 (set wins).
- gpio_o reflects the GPIO register directly, with no extra latency beyond the write edge.

Test Plan:
- Reset, then read GPIO, CNT and STATUS → 0, small counter value, 0; err_o = 0; gpio_o = 0.
- Write 0x1122_3344 to 0x0000_0010 with be = 1111, then write 0xAABB_CCDD to the same address with be = 0101, then read next cycle → data_rdata_o = 0x11BB_33DD one cycle after the read request.
- Write GPIO 0xFFFF_FFFF with be = 0011 → gpio_o = 0x0000_FFFF after the edge. Read GPIO with be = 0000 → 0x0000_FFFF.
- Write CNT = 0xFFFF_FFFE, then idle 2 cycles, then read → 0x0000_0000 (wrapped). A write with be = 0001 and data 0x05 on counter value 0x0000_1234 → counter = 0x0000_1205 next cycle.
- Read 0x0000_1000 (RAM_WORDS = 1024) → data_rdata_o = 0, err_o = 1. Read 0x8000_000C → err stays 1. Write STATUS = 1 → err_o = 0. Write STATUS = 1 in the same cycle as an unmapped access → err_o stays 1.
- Issue a read, then assert arst_i before the next edge → data_rdata_o = 0 and gpio_o = 0 immediately. After release, the RAM word written pre-reset reads back unchanged.
